// File: rtl/lsu_align_unit.sv
// rtl/lsu_align_unit.sv - load/store alignment unit in front of the data memory
//
// Accepts one load/store at a time from the core. Aligned accesses pass straight
// to memory with the memory's native funct3. Misaligned H/W accesses are split
// into two aligned word accesses (read-modify-write for stores, local merge and
// extension for loads). One registered response pulse per request.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   req_valid/ready     request handshake (ready only in IDLE)
//   req_write           1 = store, 0 = load
//   req_funct3          000 B, 001 H, 010 W, 100 BU, 101 HU
//   req_addr/wdata      byte address, store data (low bytes for B/H)
//   resp_valid          one-cycle response pulse
//   resp_rdata          extended load data, 0 for stores and errors
//   resp_err            illegal funct3 or rejected misaligned access
//   mem_write/addr/funct3/wdata  memory request
//   mem_rdata           combinational memory read data (pre-write contents)

module lsu_align_unit #(
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [2:0]  mem_funct3,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACC_LO, ACC_HI, RESP} state_t;

  state_t      state, state_nx;
  logic        wr_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q, wdata_q, lo_word;

  logic        illegal, misaligned, reject, split;
  logic [4:0]  sh;
  logic [31:0] size_mask, a0, a1, merged, ld_data;
  logic [63:0] lane_mask, lane_data;

  assign illegal    = (f3_q == 3'b011) || (f3_q[2:1] == 2'b11) || (f3_q[2] && wr_q);
  assign misaligned = ((f3_q[1:0] == 2'b01) && addr_q[0]) ||
                      ((f3_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));
  assign reject     = illegal || (misaligned && !ALLOW_MISALIGNED);
  assign split      = misaligned && !reject;

  assign sh        = {addr_q[1:0], 3'b000};
  assign a0        = {addr_q[31:2], 2'b00};
  assign a1        = a0 + 32'd4;

  // Store bytes laid across the two-word window starting at a0. Masking to the
  // access size keeps a halfword from clobbering neighbouring bytes.
  assign size_mask = f3_q[1] ? 32'hFFFF_FFFF : 32'h0000_FFFF;
  assign lane_mask = {32'b0, size_mask} << sh;
  assign lane_data = {32'b0, wdata_q & size_mask} << sh;

  // Load window: high word is the current (A1) read, low word was captured at A0.
  assign merged = 32'({mem_rdata, lo_word} >> sh);

  always_comb begin
    ld_data = merged;
    if (!f3_q[1]) begin
      if (f3_q[2]) ld_data = {16'b0, merged[15:0]};
      else         ld_data = {{16{merged[15]}}, merged[15:0]};
    end
  end

  always_comb begin
    state_nx   = state;
    req_ready  = (state == IDLE);
    mem_write  = 1'b0;
    mem_addr   = 32'b0;
    mem_funct3 = 3'b000;
    mem_wdata  = 32'b0;
    case (state)
      IDLE: if (req_valid) state_nx = ACC_LO;
      ACC_LO: begin
        if (reject) begin
          state_nx = RESP;
        end else if (split) begin
          mem_addr   = a0;
          mem_funct3 = 3'b010;
          mem_write  = wr_q;
          mem_wdata  = (mem_rdata & ~lane_mask[31:0]) | lane_data[31:0];
          state_nx   = ACC_HI;
        end else begin
          mem_addr   = addr_q;
          mem_funct3 = f3_q;
          mem_write  = wr_q;
          mem_wdata  = wdata_q;
          state_nx   = RESP;
        end
      end
      ACC_HI: begin
        mem_addr   = a1;
        mem_funct3 = 3'b010;
        mem_write  = wr_q;
        mem_wdata  = (mem_rdata & ~lane_mask[63:32]) | lane_data[63:32];
        state_nx   = RESP;
      end
      RESP: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      wr_q       <= 1'b0;
      f3_q       <= 3'b000;
      addr_q     <= 32'b0;
      wdata_q    <= 32'b0;
      lo_word    <= 32'b0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'b0;
      resp_err   <= 1'b0;
    end else begin
      state      <= state_nx;
      resp_valid <= 1'b0;
      case (state)
        IDLE: if (req_valid) begin
          wr_q    <= req_write;
          f3_q    <= req_funct3;
          addr_q  <= req_addr;
          wdata_q <= req_wdata;
        end
        ACC_LO: begin
          if (reject) begin
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_rdata <= 32'b0;
          end else if (split) begin
            if (!wr_q) lo_word <= mem_rdata;
          end else begin
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= wr_q ? 32'b0 : mem_rdata;
          end
        end
        ACC_HI: begin
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= wr_q ? 32'b0 : ld_data;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/lsu_align_unit.md
Name: lsu_align_unit

Overview:
- Load/store unit directly upstream of the data memory. Accepts one load/store request at a time from the core over a valid/ready handshake.
- Aligned accesses pass through to the memory unchanged, using the memory's native byte/half/word funct3 encoding.
- Misaligned halfword/word accesses are split into two aligned full-word accesses. Stores use read-modify-write; loads merge and extend locally.
- Returns a single registered response per request.

Parameters:
- ALLOW_MISALIGNED, 1: 1 = split misaligned accesses; 0 = reject them with resp_err and no memory access.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  request valid
- req_ready  out  1  unit can accept a request
- req_write  in  1  1 = store, 0 = load
- req_funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  32  byte address
- req_wdata  in  32  store data (low bytes used for B/H)
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  illegal funct3, or misaligned with ALLOW_MISALIGNED=0
- mem_write  out  1  memory write enable
- mem_addr  out  32  memory byte address
- mem_funct3  out  3  memory access size/sign
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data (combinational from mem_addr/mem_funct3, reflects pre-write contents)

Behaviour:
- States are IDLE, ACC_LO, ACC_HI, RESP.
- Reset (asynchronous):
  - state=IDLE.
  - resp_valid=0, resp_rdata=0, resp_err=0, mem_write=0.
  - All latched request fields = 0.
- Handshake:
  - req_ready = (state==IDLE).
  - A handshake (req_valid & req_ready at posedge) latches write/funct3/addr/wdata and moves to ACC_LO.
  - Request inputs are ignored outside IDLE.
- Classification (on the latched request):
  - Illegal: funct3 is 011, 110 or 111; also funct3=100/101 with write=1.
  - Misaligned: H/HU with addr[0]=1, or W with addr[1:0]!=0.
  - B/BU are always aligned.
- Illegal request, or misaligned with ALLOW_MISALIGNED=0:
  - ACC_LO drives mem_write=0.
  - RESP then asserts resp_err=1 and resp_rdata=0.
- Aligned request:
  - ACC_LO drives mem_addr=addr, mem_funct3=funct3, mem_wdata=wdata, mem_write=write.
  - For a load, resp_rdata <= mem_rdata at the end of ACC_LO.
  - Next state is RESP.
- Misaligned request:
  - Let o = addr[1:0], n = 2 or 4 bytes, A0 = {addr[31:2],2'b00}, A1 = A0+4 (32-bit wrap).
  - In both ACC_LO and ACC_HI: mem_funct3=010.
  - ACC_LO: mem_addr=A0.
    - Load: lo_word <= mem_rdata.
    - Store: mem_write=1; mem_wdata = mem_rdata with bytes o..3 replaced by wdata bytes 0..(3-o).
  - ACC_HI: mem_addr=A1.
    - Store: mem_write=1; mem_wdata = mem_rdata with bytes 0..(o+n-5) replaced by the remaining wdata bytes.
    - Load: form {mem_rdata, lo_word} >> 8*o, take the low n bytes, sign-extend (H) or zero-extend (HU/W); register into resp_rdata.
  - Next state is RESP.
- RESP:
  - resp_valid=1 for exactly one cycle, then IDLE.
  - No response backpressure; the core must sample resp_valid.
  - resp_err is valid only with resp_valid.
- Latency, counted from the handshake edge:
  - Aligned or error: resp_valid high in cycle 2.
  - Misaligned: resp_valid high in cycle 3.
  - Back-to-back requests are accepted the cycle after RESP.
- mem_write is 0 in IDLE and RESP; mem_addr/mem_wdata are don't-care when mem_write=0 and the state is not an access state.
- Reset asserted mid-operation: abort to IDLE; no response is issued. A lo-word write already performed is not rolled back.

Test Plan:
- Aligned word store/load: SW 0x100 ← 0xDEADBEEF, then LW 0x100 → resp_rdata=0xDEADBEEF, resp_err=0, resp_valid in cycle 2 after the handshake.
- Byte extension: SW 0x100 ← 0x80FF0000.
  - LB 0x103 → 0xFFFFFF80.
  - LBU 0x103 → 0x00000080.
  - LHU 0x102 → 0x000080FF.
  - LH 0x102 → 0xFFFF80FF.
- Misaligned store: preload 0x200=0xAABBCCDD and 0x204=0x55667788. SW 0x201 ← 0x11223344 → 0x200=0x223344DD, 0x204=0x55667711; resp_valid in cycle 3; exactly two mem_write pulses.
- Misaligned loads after the previous scenario:
  - LW 0x201 → 0x11223344.
  - LH 0x203 → 0x00001122.
  - Store 0x8000 into halfword 0x203, then LH 0x203 → 0xFFFF8000 and LHU 0x203 → 0x00008000.
- Errors:
  - funct3=011 load → resp_err=1, resp_rdata=0, no mem_write.
  - With ALLOW_MISALIGNED=0, SW 0x201 → resp_err=1, memory unchanged.
- Reset mid-op: drop rst during ACC_HI of a misaligned SW → resp_valid never pulses; all outputs are 0 and req_ready=1 after release; the next aligned LW completes normally.
